// File: rtl/booth_product_accumulator_if.sv
// Stream bundle between a Booth product source and the frame accumulator:
// product beats in, one accumulated result per frame out.
interface booth_product_accumulator_if #(
  parameter int N     = 32,
  parameter int G     = 8,
  parameter int LEN_W = 8
);
  localparam int W = 2*N + G;

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_p;
  logic             in_last;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_acc;
  logic             out_sat;
  logic [LEN_W-1:0] out_count;

  modport master (
    output in_valid, in_p, in_last, clr, out_ready,
    input  in_ready, out_valid, out_acc, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_p, in_last, clr, out_ready,
    output in_ready, out_valid, out_acc, out_sat, out_count
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// Frame accumulator for signed Booth products: guard-bit accumulation with
// saturation, sticky overflow flag and a per-frame term counter.
module booth_product_accumulator #(
  parameter int N     = 32,
  parameter int G     = 8,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst,
  booth_product_accumulator_if.slave bus
);
  localparam int W = 2*N + G;

  typedef enum logic {ACC, HOLD} state_e;

  state_e           state_q;
  logic [W-1:0]     acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [LEN_W-1:0] count_q, count_d;

  logic [W-1:0]     baseAcc;
  logic             baseSat;
  logic [LEN_W-1:0] baseCount;
  logic [W:0]       sum;
  logic             beat;

  assign beat = bus.in_valid && (state_q == ACC);

  // A clr arriving with a beat starts the frame afresh from that beat.
  always_comb begin
    baseAcc   = bus.clr ? '0 : acc_q;
    baseSat   = bus.clr ? 1'b0 : sat_q;
    baseCount = bus.clr ? '0 : count_q;
    sum       = {baseAcc[W-1], baseAcc} + {{(G+1){bus.in_p[2*N-1]}}, bus.in_p};
    acc_d     = sum[W-1:0];
    sat_d     = baseSat;
    if (sum[W] != sum[W-1]) begin
      acc_d = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      sat_d = 1'b1;
    end
    count_d = (&baseCount) ? baseCount : baseCount + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            if (bus.in_last) state_q <= HOLD;
          end else if (bus.clr) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = acc_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Drives three accumulator configurations (default, G=1, LEN_W=2) with shared
// stimulus and compares each against a plain-arithmetic frame model.
module tb_booth_product_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inLast, clrReq, outReady;
  logic [63:0] inP;

  int vectors = 0;
  int miscompares = 0;
  logic signed [63:0] frameQ[$];

  localparam logic signed [63:0] PMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] PMIN = 64'sh8000_0000_0000_0000;

  always #5 clk = ~clk;

  booth_product_accumulator_if #(.N(32), .G(8), .LEN_W(8)) busA ();
  booth_product_accumulator_if #(.N(32), .G(1), .LEN_W(8)) busB ();
  booth_product_accumulator_if #(.N(32), .G(8), .LEN_W(2)) busC ();

  assign busA.in_valid = inValid;  assign busA.in_p = inP;  assign busA.in_last = inLast;
  assign busA.clr = clrReq;        assign busA.out_ready = outReady;
  assign busB.in_valid = inValid;  assign busB.in_p = inP;  assign busB.in_last = inLast;
  assign busB.clr = clrReq;        assign busB.out_ready = outReady;
  assign busC.in_valid = inValid;  assign busC.in_p = inP;  assign busC.in_last = inLast;
  assign busC.clr = clrReq;        assign busC.out_ready = outReady;

  booth_product_accumulator #(.N(32), .G(8), .LEN_W(8)) dutA (.clk(clk), .rst(rst), .bus(busA));
  booth_product_accumulator #(.N(32), .G(1), .LEN_W(8)) dutB (.clk(clk), .rst(rst), .bus(busB));
  booth_product_accumulator #(.N(32), .G(8), .LEN_W(2)) dutC (.clk(clk), .rst(rst), .bus(busC));

  task automatic checkResult(input string tag, input logic signed [127:0] obs,
                             input logic signed [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Running sum of the current frame with clamping after every term.
  function automatic void model(input int w, input int lw, output logic signed [127:0] acc,
                                output logic sat, output logic signed [127:0] cnt);
    logic signed [127:0] one, maxV, minV, cap;
    one  = 1;
    maxV = (one << (w-1)) - 1;
    minV = -(one << (w-1));
    cap  = (one << lw) - 1;
    acc  = 0;
    sat  = 1'b0;
    foreach (frameQ[i]) begin
      acc = acc + frameQ[i];
      if (acc > maxV) begin acc = maxV; sat = 1'b1; end
      else if (acc < minV) begin acc = minV; sat = 1'b1; end
    end
    cnt = (frameQ.size() > cap) ? cap : frameQ.size();
  endfunction

  task automatic checkAll(input string tag);
    logic signed [127:0] eAcc, eCnt;
    logic eSat;
    model(72, 8, eAcc, eSat, eCnt);
    checkResult({tag, "/A.acc"}, 128'($signed(busA.out_acc)), eAcc);
    checkResult({tag, "/A.sat"}, {127'b0, busA.out_sat}, {127'b0, eSat});
    checkResult({tag, "/A.cnt"}, {120'b0, busA.out_count}, eCnt);
    model(65, 8, eAcc, eSat, eCnt);
    checkResult({tag, "/B.acc"}, 128'($signed(busB.out_acc)), eAcc);
    checkResult({tag, "/B.sat"}, {127'b0, busB.out_sat}, {127'b0, eSat});
    checkResult({tag, "/B.cnt"}, {120'b0, busB.out_count}, eCnt);
    model(72, 2, eAcc, eSat, eCnt);
    checkResult({tag, "/C.acc"}, 128'($signed(busC.out_acc)), eAcc);
    checkResult({tag, "/C.sat"}, {127'b0, busC.out_sat}, {127'b0, eSat});
    checkResult({tag, "/C.cnt"}, {126'b0, busC.out_count}, eCnt);
  endtask

  task automatic checkOutput(input string tag, input logic expValid, input logic expReady);
    checkResult({tag, "/out_valid"}, {127'b0, busA.out_valid}, {127'b0, expValid});
    checkResult({tag, "/in_ready"}, {127'b0, busA.in_ready}, {127'b0, expReady});
    checkAll(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [63:0] p, input logic last, input logic withClr);
    int waitCycles = 0;
    inValid = 1'b1; inP = p; inLast = last; clrReq = withClr;
    while (!busA.in_ready && waitCycles < 50) begin
      tick();
      waitCycles++;
    end
    if (!busA.in_ready) begin
      checkResult("beatTimeout", 0, 1);
      inValid = 1'b0; clrReq = 1'b0;
      return;
    end
    tick();
    inValid = 1'b0; clrReq = 1'b0; inLast = 1'b0;
    if (withClr) frameQ.delete();
    frameQ.push_back(p);
    if (last) checkOutput("frameEnd", 1'b1, 1'b0);
    else      checkOutput("running", 1'b0, 1'b1);
  endtask

  task automatic releaseResult();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    frameQ.delete();
    checkOutput("released", 1'b0, 1'b1);
  endtask

  task automatic clrAlone();
    inValid = 1'b0; clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    frameQ.delete();
    checkOutput("clrAlone", 1'b0, 1'b1);
  endtask

  task automatic resetPulse(input string tag);
    rst = 1'b0; inValid = 1'b1; inP = 64'd5; inLast = 1'b1;
    tick();
    rst = 1'b1; inValid = 1'b0; inLast = 1'b0;
    frameQ.delete();
    checkOutput(tag, 1'b0, 1'b1);
    checkResult({tag, "/accZero"}, 128'($signed(busA.out_acc)), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [63:0] v;
    int len, holdCycles;
    rst = 1'b0; inValid = 1'b0; inLast = 1'b0; clrReq = 1'b0; outReady = 1'b0; inP = '0;
    tick();
    checkOutput("resetInit", 1'b0, 1'b1);
    rst = 1'b1;
    tick();

    // Basic frame
    applyStimulus(-1500, 1'b0, 1'b0);
    applyStimulus(100, 1'b0, 1'b0);
    applyStimulus(1500, 1'b0, 1'b0);
    applyStimulus(-22500, 1'b1, 1'b0);
    checkResult("basic.accConst", 128'($signed(busA.out_acc)), -22400);
    checkResult("basic.cntConst", {120'b0, busA.out_count}, 4);
    releaseResult();

    // Backpressure: a pending beat waits out the hold
    applyStimulus(150, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    inValid = 1'b1; inP = 64'd7; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bpHold", 1'b1, 1'b0);
      checkResult("bp.accConst", 128'($signed(busA.out_acc)), 150);
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    frameQ.delete();
    checkOutput("bpRelease", 1'b0, 1'b1);
    tick();
    inValid = 1'b0; inLast = 1'b0;
    frameQ.push_back(7);
    checkOutput("bpNext", 1'b1, 1'b0);
    checkResult("bpNext.accConst", 128'($signed(busA.out_acc)), 7);
    releaseResult();

    // Saturation on the G=1 instance
    for (int i = 0; i < 3; i++) applyStimulus(PMAX, i == 2, 1'b0);
    checkResult("satPos.const", 128'($signed(busB.out_acc)), (128'sd1 <<< 64) - 1);
    checkResult("satPos.sat", {127'b0, busB.out_sat}, 1);
    releaseResult();
    for (int i = 0; i < 3; i++) applyStimulus(PMIN, i == 2, 1'b0);
    checkResult("satNeg.const", 128'($signed(busB.out_acc)), -(128'sd1 <<< 64));
    releaseResult();
    applyStimulus(5, 1'b1, 1'b0);
    checkResult("satClear.sat", {127'b0, busB.out_sat}, 0);
    releaseResult();

    // clr with a beat, then clr alone
    applyStimulus(10, 1'b0, 1'b0);
    applyStimulus(20, 1'b0, 1'b0);
    applyStimulus(40, 1'b1, 1'b1);
    checkResult("clrBeat.accConst", 128'($signed(busA.out_acc)), 40);
    checkResult("clrBeat.cntConst", {120'b0, busA.out_count}, 1);
    releaseResult();
    applyStimulus(10, 1'b0, 1'b0);
    clrAlone();
    applyStimulus(3, 1'b1, 1'b0);
    checkResult("clrAlone.accConst", 128'($signed(busA.out_acc)), 3);
    releaseResult();

    // Reset mid-frame and during a stalled hold
    applyStimulus(99, 1'b0, 1'b0);
    resetPulse("resetMid");
    applyStimulus(42, 1'b1, 1'b0);
    tick();
    checkOutput("holdStall", 1'b1, 1'b0);
    resetPulse("resetHold");

    // Term counter saturation on the LEN_W=2 instance
    for (int i = 0; i < 5; i++) applyStimulus(1, i == 4, 1'b0);
    checkResult("cntSat.const", {126'b0, busC.out_count}, 3);
    checkResult("cntSat.acc", 128'($signed(busC.out_acc)), 5);
    releaseResult();

    // Randomized frames, biased toward extremes to exercise clamping
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 3))
          0: v = 64'($signed($urandom_range(0, 2000))) - 64'sd1000;
          1: v = PMAX - 64'($urandom_range(0, 3));
          2: v = PMIN + 64'($urandom_range(0, 3));
          default: v = {$urandom, $urandom};
        endcase
        if ($urandom_range(0, 4) == 0) begin
          inValid = 1'b0;
          tick();
          checkOutput("idle", 1'b0, 1'b1);
        end
        if ($urandom_range(0, 9) == 0) clrAlone();
        applyStimulus(v, b == len - 1, $urandom_range(0, 9) == 0);
      end
      holdCycles = $urandom_range(0, 3);
      for (int h = 0; h < holdCycles; h++) begin
        inValid = $urandom_range(0, 1) == 1;
        clrReq  = $urandom_range(0, 1) == 1;
        tick();
        checkOutput("randHold", 1'b1, 1'b0);
      end
      inValid = 1'b0; clrReq = 1'b0;
      releaseResult();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
